// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared opcode and FSM state types for the sequential ALU.
//   alu_op_e      - 4-bit opcode encoding of alu_ctrl
//   alu_state_e   - control FSM states (IDLE, BUSY, DONE)
//   is_multicycle - true for the iterative MULU/DIVU/REMU operations
package seq_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLT  = 4'd5,
    OP_SLTU = 4'd6,
    OP_SLL  = 4'd7,
    OP_SRL  = 4'd8,
    OP_SRA  = 4'd9,
    OP_MULU = 4'd10,
    OP_DIVU = 4'd11,
    OP_REMU = 4'd12
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  function automatic logic is_multicycle(input alu_op_e op);
    return (op == OP_MULU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// seq_alu_muldiv: iterative unsigned multiply (shift-add) and restoring
// divide, one bit per cycle, DATA_WIDTH iterations.
//   clk, rst_n   - clock, asynchronous active-low reset
//   start        - pulse: load operands and begin iterating
//   op           - OP_MULU / OP_DIVU / OP_REMU, captured on start
//   op1, op2     - operands, captured on start (op2 must be nonzero for div)
//   done         - high during the final iteration cycle
//   result       - value after the final iteration, valid while done=1
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  alu_op_e               op,
  input  logic [DATA_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0] op2,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  logic          busy;
  logic [CW-1:0] count;
  alu_op_e       op_reg;
  logic [2*W-1:0] acc, mcand;
  logic [W-1:0]   mplier;
  logic [W-1:0]   rem, quo, divisor;

  logic [2*W-1:0] acc_next;
  logic [W:0]     shifted, trial;
  logic [W-1:0]   rem_next, quo_next;

  // One shift-add step and one restoring-division step per cycle. The
  // restored remainder is always below the divisor, so W bits suffice.
  always_comb begin
    acc_next = mplier[0] ? (acc + mcand) : acc;
    shifted  = {rem, quo[W-1]};
    trial    = shifted - {1'b0, divisor};
    rem_next = trial[W] ? shifted[W-1:0] : trial[W-1:0];
    quo_next = {quo[W-2:0], ~trial[W]};
  end

  assign done = busy && (count == CW'(W - 1));

  // The top registers the result on the done cycle, so expose the value
  // that this final step produces rather than the stale register.
  always_comb begin
    result = '0;
    case (op_reg)
      OP_MULU: result = acc_next[W-1:0];
      OP_DIVU: result = quo_next;
      OP_REMU: result = rem_next;
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      count   <= '0;
      op_reg  <= OP_ADD;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
    end else if (start) begin
      busy    <= 1'b1;
      count   <= '0;
      op_reg  <= op;
      acc     <= '0;
      mcand   <= {{W{1'b0}}, op1};
      mplier  <= op2;
      rem     <= '0;
      quo     <= op1;
      divisor <= op2;
    end else if (busy) begin
      count  <= count + 1'b1;
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      rem    <= rem_next;
      quo    <= quo_next;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready handshakes on both sides.
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid / in_ready   - request handshake (in_ready only in IDLE)
//   alu_ctrl              - opcode (alu_op_e encoding; 13..15 give 0)
//   alu_op1, alu_op2      - operands
//   out_valid / out_ready - result handshake, outputs held until taken
//   result, eq            - operation result, op1==op2 at accept
//   div_by_zero           - DIVU/REMU issued with op2 == 0
// All outputs come straight from registers.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] alu_ctrl,
  input  logic [DATA_WIDTH-1:0] alu_op1,
  input  logic [DATA_WIDTH-1:0] alu_op2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  eq,
  output logic                  div_by_zero
);

  localparam int W   = DATA_WIDTH;
  localparam int SHW = $clog2(DATA_WIDTH);

  alu_state_e state;
  logic       in_ready_reg, out_valid_reg, eq_reg, dbz_reg;
  logic [W-1:0] result_reg;

  alu_op_e      op_code;
  logic         accept, dbz_hit, mdu_start, mdu_done;
  logic [SHW-1:0] shamt;
  logic [W-1:0] simple_result, mdu_result;

  assign op_code   = alu_op_e'(4'(alu_ctrl));
  assign accept    = in_valid && in_ready_reg;
  assign dbz_hit   = ((op_code == OP_DIVU) || (op_code == OP_REMU)) && (alu_op2 == '0);
  assign mdu_start = accept && is_multicycle(op_code) && !dbz_hit;
  assign shamt     = alu_op2[SHW-1:0];

  always_comb begin
    simple_result = '0;
    case (op_code)
      OP_ADD:  simple_result = alu_op1 + alu_op2;
      OP_SUB:  simple_result = alu_op1 - alu_op2;
      OP_AND:  simple_result = alu_op1 & alu_op2;
      OP_OR:   simple_result = alu_op1 | alu_op2;
      OP_XOR:  simple_result = alu_op1 ^ alu_op2;
      OP_SLT:  simple_result = {{(W-1){1'b0}}, ($signed(alu_op1) < $signed(alu_op2))};
      OP_SLTU: simple_result = {{(W-1){1'b0}}, (alu_op1 < alu_op2)};
      OP_SLL:  simple_result = alu_op1 << shamt;
      OP_SRL:  simple_result = alu_op1 >> shamt;
      OP_SRA:  simple_result = $unsigned($signed(alu_op1) >>> shamt);
      default: simple_result = '0;
    endcase
  end

  seq_alu_muldiv #(.DATA_WIDTH(DATA_WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (mdu_start),
    .op     (op_code),
    .op1    (alu_op1),
    .op2    (alu_op2),
    .done   (mdu_done),
    .result (mdu_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      eq_reg        <= 1'b0;
      dbz_reg       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            in_ready_reg <= 1'b0;
            eq_reg       <= (alu_op1 == alu_op2);
            dbz_reg      <= dbz_hit;
            if (mdu_start) begin
              state <= BUSY;
            end else begin
              // Simple ops, unknown opcodes and divide-by-zero finish here.
              state         <= DONE;
              out_valid_reg <= 1'b1;
              if (dbz_hit)
                result_reg <= (op_code == OP_DIVU) ? {W{1'b1}} : alu_op1;
              else
                result_reg <= simple_result;
            end
          end
        end
        BUSY: begin
          if (mdu_done) begin
            state         <= DONE;
            out_valid_reg <= 1'b1;
            result_reg    <= mdu_result;
          end
        end
        DONE: begin
          if (out_ready) begin
            state         <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_reg;
  assign out_valid   = out_valid_reg;
  assign result      = result_reg;
  assign eq          = eq_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed scoreboard bench for seq_alu at DATA_WIDTH=8.
// The driver pushes hand-computed expectations at accept; an independent
// monitor pops them when out_valid appears and checks value, latency,
// output stability while held and in_ready behaviour.
module tb_seq_alu;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   alu_ctrl = 4'd0;
  logic [W-1:0] alu_op1 = '0;
  logic [W-1:0] alu_op2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         eq;
  logic         div_by_zero;

  seq_alu #(.DATA_WIDTH(W), .CTRL_WIDTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_ctrl    (alu_ctrl),
    .alu_op1     (alu_op1),
    .alu_op2     (alu_op2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .eq          (eq),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string        name;
    logic [W-1:0] res;
    logic         eq;
    logic         dbz;
    int           lat;
    int           hold;
    int           acc_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
    end
  endtask

  // Hold the request until in_ready is seen, then push the expectation for
  // the edge that will accept it.
  task automatic issue(input string nm, input logic [3:0] c, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] r, input logic e,
                       input logic d, input int lat, input int hold);
    exp_t x;
    int   n;
    in_valid = 1'b1;
    alu_ctrl = c;
    alu_op1  = a;
    alu_op2  = b;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s_accept_timeout: in_ready stayed 0, expected 1", nm);
        in_valid = 1'b0;
        return;
      end
    end
    x.name = nm; x.res = r; x.eq = e; x.dbz = d;
    x.lat = lat; x.hold = hold; x.acc_cyc = cyc + 1;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    alu_op1  = 8'($urandom);
    alu_op2  = 8'($urandom);
  endtask

  // Monitor
  logic         active = 1'b0;
  logic         stable_ok;
  logic         ir_ok;
  int           wait_cnt;
  logic [W-1:0] snap_res;
  logic         snap_eq, snap_dbz;
  string        cur_name;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active    = 1'b0;
        out_ready = 1'b0;
      end else begin
        if (active && !out_valid) begin
          // Handshake completed on the previous edge.
          chk({cur_name, "_stable"}, {31'd0, stable_ok}, 32'd1);
          chk({cur_name, "_idle_after"}, {31'd0, in_ready}, 32'd1);
          active    = 1'b0;
          out_ready = 1'b0;
        end else if (active && out_valid) begin
          if (result !== snap_res || eq !== snap_eq || div_by_zero !== snap_dbz || in_ready)
            stable_ok = 1'b0;
          if (wait_cnt == 0) out_ready = 1'b1;
          else wait_cnt--;
        end else if (!active && out_valid) begin
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_result: got 0x%0h, expected no output", result);
          end else begin
            exp_t x;
            x = sb_q.pop_front();
            cur_name = x.name;
            $display("txn %-10s result=0x%02h eq=%0b dbz=%0b lat=%0d", x.name, result, eq,
                     div_by_zero, cyc - x.acc_cyc + 1);
            chk({x.name, "_result"}, {24'd0, result}, {24'd0, x.res});
            chk({x.name, "_eq"}, {31'd0, eq}, {31'd0, x.eq});
            chk({x.name, "_dbz"}, {31'd0, div_by_zero}, {31'd0, x.dbz});
            chk({x.name, "_latency"}, cyc - x.acc_cyc + 1, x.lat);
            chk({x.name, "_inready_low"}, {31'd0, ir_ok}, 32'd1);
            chk({x.name, "_inready_done"}, {31'd0, in_ready}, 32'd0);
            active    = 1'b1;
            stable_ok = 1'b1;
            snap_res  = result;
            snap_eq   = eq;
            snap_dbz  = div_by_zero;
            wait_cnt  = x.hold;
            if (wait_cnt == 0) out_ready = 1'b1;
            else wait_cnt--;
          end
        end
        // Between accept and result, in_ready must stay low.
        if (!active && sb_q.size() > 0 && cyc >= sb_q[0].acc_cyc && in_ready)
          ir_ok = 1'b0;
        if (!active && !out_valid && sb_q.size() == 0)
          ir_ok = 1'b1;
      end
    end
  end

  initial begin
    int n;
    ir_ok = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_result", {24'd0, result}, 32'd0);
    chk("reset_eq", {31'd0, eq}, 32'd0);
    chk("reset_dbz", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

    //     name          op     op1    op2    result eq dbz lat hold
    issue("add_wrap",   4'd0,  8'hFF, 8'h01, 8'h00, 0, 0, 1, 0);
    issue("sub_eq",     4'd1,  8'h05, 8'h05, 8'h00, 1, 0, 1, 0);
    issue("slt",        4'd5,  8'h80, 8'h01, 8'h01, 0, 0, 1, 0);
    issue("sltu",       4'd6,  8'h80, 8'h01, 8'h00, 0, 0, 1, 0);
    issue("sra",        4'd9,  8'h80, 8'h0B, 8'hF0, 0, 0, 1, 0);
    issue("srl",        4'd8,  8'h80, 8'h0B, 8'h10, 0, 0, 1, 0);
    issue("sll",        4'd7,  8'h81, 8'h01, 8'h02, 0, 0, 1, 0);
    issue("xor",        4'd4,  8'hA5, 8'h0F, 8'hAA, 0, 0, 1, 0);
    issue("and_or",     4'd3,  8'hA0, 8'h05, 8'hA5, 0, 0, 1, 0);
    issue("op13",       4'd13, 8'h12, 8'h34, 8'h00, 0, 0, 1, 0);
    issue("mulu",       4'd10, 8'h0F, 8'h11, 8'hFF, 0, 0, 9, 0);
    issue("mulu_ovf",   4'd10, 8'h10, 8'h20, 8'h00, 0, 0, 9, 0);
    issue("divu",       4'd11, 8'hC8, 8'h07, 8'h1C, 0, 0, 9, 0);
    issue("remu",       4'd12, 8'hC8, 8'h07, 8'h04, 0, 0, 9, 0);
    issue("divu_z",     4'd11, 8'h2A, 8'h00, 8'hFF, 0, 1, 1, 0);
    issue("remu_z",     4'd12, 8'h2A, 8'h00, 8'h2A, 0, 1, 1, 0);
    // Result held 5 cycles; the following ADD is presented meanwhile and
    // must wait for the handshake.
    issue("mulu_hold",  4'd10, 8'h03, 8'h03, 8'h09, 1, 0, 9, 5);
    issue("add_waited", 4'd0,  8'h10, 8'h22, 8'h32, 0, 0, 1, 0);
    issue("divu_z2",    4'd11, 8'h55, 8'h00, 8'hFF, 0, 1, 1, 0);

    // Reset in the middle of a divide.
    issue("divu_rst",   4'd11, 8'hC8, 8'h07, 8'h1C, 0, 0, 9, 0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_result", {24'd0, result}, 32'd0);
    chk("midrst_eq", {31'd0, eq}, 32'd0);
    chk("midrst_dbz", {31'd0, div_by_zero}, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("postrst_in_ready", {31'd0, in_ready}, 32'd1);
    ir_ok = 1'b1;
    issue("add_postrst", 4'd0, 8'h12, 8'h34, 8'h46, 0, 0, 1, 0);
    issue("remu_post",   4'd12, 8'hFF, 8'h10, 8'h0F, 0, 0, 9, 0);

    n = 0;
    while ((sb_q.size() > 0 || active) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d results pending, expected 0", sb_q.size());
    end
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, multi-cycle successor to the single-cycle datapath ALU. It executes integer ALU, shift, unsigned multiply and unsigned divide/remainder operations behind a valid/ready handshake. Simple operations complete in 1 cycle; multiply and divide iterate for DATA_WIDTH cycles. It sits in the execute stage, between operand read and writeback, and stalls issue through `in_ready`.

## Interface
- `DATA_WIDTH`, 32: operand/result width. Must be a power of 2 and at least 4.
- `CTRL_WIDTH`, 4: width of `alu_ctrl`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: operation request.
- `in_ready` out 1: block can accept a request.
- `alu_ctrl` in CTRL_WIDTH: opcode, see Operation.
- `alu_op1` in DATA_WIDTH: operand 1 (rs1).
- `alu_op2` in DATA_WIDTH: operand 2 (rs2/imm).
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts the result.
- `result` out DATA_WIDTH: operation result.
- `eq` out 1: `alu_op1 == alu_op2`, sampled at accept.
- `div_by_zero` out 1: DIVU/REMU issued with `alu_op2 == 0`.

## Operation
- Opcodes:
  - ADD=0, SUB=1, AND=2, OR=3, XOR=4.
  - SLT=5 (signed), SLTU=6.
  - SLL=7, SRL=8, SRA=9.
  - MULU=10 (low DATA_WIDTH bits of the product), DIVU=11, REMU=12.
  - Codes 13–15 give `result = 0`, complete as simple ops, and raise no error.
- Accept occurs when `in_valid && in_ready`. Operands, opcode and `eq` are registered at accept; the input buses are don't-care afterwards.
- Arithmetic is modulo 2^DATA_WIDTH, with no carry/overflow output.
- SLT/SLTU produce 1 or 0, zero-extended.
- Shift amount is `alu_op2[$clog2(DATA_WIDTH)-1:0]`; upper bits are ignored.
- MULU is a shift-add with one bit per cycle, using a 2·DATA_WIDTH accumulator truncated at output.
- DIVU/REMU use restoring division, one quotient bit per cycle.
- Divide by zero completes without iterating:
  - DIVU returns all-ones.
  - REMU returns `alu_op1`.
  - `div_by_zero` = 1 with the result.
- FSM states:
  - IDLE: `in_ready`=1. On accept, a simple op, an unknown opcode or a divide-by-zero goes to DONE; MULU/DIVU/REMU with a nonzero divisor go to BUSY with the iteration counter at 0.
  - BUSY: counter increments each cycle. When the counter reaches DATA_WIDTH-1, the FSM goes to DONE on the next edge.
  - DONE: `out_valid`=1 and `result`, `eq`, `div_by_zero` stable. On `out_ready`, return to IDLE.
- `in_ready` = 1 only in IDLE. There is no overlap of accept and result.
- `out_valid` must not drop, and outputs must not change, until `out_ready` is seen.

## Timing
- Reset (asynchronous, any state) forces:
  - FSM = IDLE.
  - `in_ready`=1 once `rst_n` deasserts.
  - `out_valid`=0, `result`=0, `eq`=0, `div_by_zero`=0.
  - Counter and accumulators cleared.
  - An operation in flight is discarded, with no output produced.
- Simple op or div-by-zero accepted at edge N: `out_valid`=1 after edge N+1 (latency 1).
- MULU/DIVU/REMU accepted at edge N: `out_valid`=1 after edge N+DATA_WIDTH+1.
- DONE with `out_ready` held high lasts exactly 1 cycle. The next accept is possible 1 cycle after the result handshake, giving a peak throughput of 1 op per 2 cycles.
- `in_valid` asserted while `in_ready`=0 is ignored. The requester must hold it until accepted.
- All outputs are driven directly from registers, with no combinational path from the inputs.

## Structure
- Package `seq_alu_pkg`:
  - `alu_op_e` enum (CTRL_WIDTH bits) with the opcodes above.
  - `alu_state_e` {IDLE, BUSY, DONE}.
  - `is_multicycle()` function.
- Sub-module `seq_alu_muldiv`:
  - Start/done pulse interface.
  - Holds the counter, accumulator and remainder/quotient registers.
- Top-level module contains:
  - The FSM.
  - The combinational simple-op unit.
  - The output registers.

## Test plan
- Use DATA_WIDTH=8 for the directed cases.
- ADD 0xFF+0x01 -> `result`=0x00 and `eq`=0, 1 cycle after accept; SUB 0x05-0x05 -> 0x00 with `eq`=1.
- SLT 0x80,0x01 -> 1; SLTU 0x80,0x01 -> 0; SRA 0x80 by op2=0x0B (amount 3) -> 0xF0.
- MULU 0x0F×0x11 -> 0xFF; DIVU 0xC8/0x07 -> 0x1C; REMU 0xC8/0x07 -> 0x04. Each has `out_valid` exactly 9 cycles after accept, and `in_ready`=0 throughout.
- DIVU 0x2A/0x00 -> 0xFF with `div_by_zero`=1, 1-cycle latency; REMU 0x2A/0x00 -> 0x2A.
- Hold `out_ready`=0 for 5 cycles in DONE -> outputs stable and `in_valid` ignored; release -> IDLE the next cycle.
- Assert `rst_n`=0 mid-DIVU (cycle 4) -> outputs read 0 immediately. After release, `in_ready`=1 and a fresh ADD completes correctly.
